// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Holds the state encodings, owner codes and the round-robin pick.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // A lone requester wins; on a tie the side that did not go last wins.
    function automatic logic pick_winner(input logic req_if, input logic req_ls,
                                         input logic prev_owner);
        if (req_if && req_ls)
            return ~prev_owner;
        return req_ls ? OWN_LS : OWN_IF;
    endfunction

endpackage

// File: rtl/mux2_to_1.sv
// Width-parameterised 2:1 steering mux used on the memory address/data paths.
module mux2_to_1 #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port shared by fetch and load/store.
// Each transaction runs IDLE (grant) -> ACCESS (MEM_LAT cycles) -> DONE (rvalid).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_sel
);

    localparam int CW = $clog2(MEM_LAT) + 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          owner, last_owner;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    logic          winner;
    logic          take;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;

    assign winner = pick_winner(if_req, ls_req, last_owner);

    mux2_to_1 #(.W(AW)) u_addr_mux (
        .sel (winner),
        .d0  (if_addr),
        .d1  (ls_addr),
        .y   (addr_mux)
    );

    // Fetch never writes, so its data leg is tied to zero.
    mux2_to_1 #(.W(DW)) u_wdata_mux (
        .sel (winner),
        .d0  ({DW{1'b0}}),
        .d1  (ls_wdata),
        .y   (wdata_mux)
    );

    always_comb begin
        state_nx  = state;
        take      = 1'b0;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        mem_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                // Reset masks grants so nothing is accepted in the reset cycle.
                take   = (if_req || ls_req) && !reset;
                if_gnt = take && (winner == OWN_IF);
                ls_gnt = take && (winner == OWN_LS);
                if (take)
                    state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_req = 1'b1;
                if (cnt == '0)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                if_rvalid = (owner == OWN_IF);
                ls_rvalid = (owner == OWN_LS);
                state_nx  = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_LS;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (take) begin
                    owner   <= winner;
                    addr_q  <= addr_mux;
                    we_q    <= (winner == OWN_LS) && ls_we;
                    wdata_q <= wdata_mux;
                    cnt     <= CW'(MEM_LAT - 1);
                end
                ST_ACCESS: begin
                    if (cnt == '0)
                        rdata_q <= we_q ? '0 : mem_rdata;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_DONE: last_owner <= owner;
                default: ;
            endcase
        end
    end

    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_req ? addr_q  : '0;
    assign mem_wdata = mem_req ? wdata_q : '0;
    assign mem_sel   = owner;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected
// grants/responses; a negedge monitor pops and compares what the DUT presents.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_sel;

    logic        b_reset, b_if_req;
    logic [31:0] b_if_addr;
    logic        b_if_gnt, b_ls_gnt, b_if_rvalid, b_ls_rvalid;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_req, b_mem_we, b_mem_sel;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is a fixed scramble of the address.
    assign mem_rdata   = mem_addr   ^ 32'h0050_0083;
    assign b_mem_rdata = b_mem_addr ^ 32'h0050_0083;

    mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_sel(mem_sel)
    );

    mem_port_arbiter #(.MEM_LAT(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
        .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .rdata(b_rdata),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_sel(b_mem_sel)
    );

    typedef struct packed {
        logic        ls;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   in_flight = 0;
    int   gnt_cyc = 0;
    int   run = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops on grant, checks bus beats during ACCESS, checks response on rvalid.
    always @(negedge clk) begin
        if (reset) begin
            in_flight = 0;
            run = 0;
        end else begin
            chk("one_gnt", {63'd0, if_gnt && ls_gnt}, 64'd0);
            chk("one_rvalid", {63'd0, if_rvalid && ls_rvalid}, 64'd0);
            if (if_gnt || ls_gnt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_gnt", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("gnt_owner", {63'd0, ls_gnt}, {63'd0, cur.ls});
                    in_flight = 1;
                    gnt_cyc = cyc;
                end
            end
            if (mem_req) begin
                run++;
                if (!in_flight) begin
                    chk("mem_req_no_owner", 64'd1, 64'd0);
                end else begin
                    chk("mem_addr", {32'd0, mem_addr}, {32'd0, cur.addr});
                    chk("mem_we", {63'd0, mem_we}, {63'd0, cur.we});
                    chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, cur.wdata});
                    chk("mem_sel", {63'd0, mem_sel}, {63'd0, cur.ls});
                end
            end else begin
                if (run != 0) chk("mem_req_width", 64'(run), 64'(LAT));
                run = 0;
                chk("idle_bus_zero", {31'd0, mem_we, mem_addr}, 64'd0);
                chk("idle_wdata_zero", {32'd0, mem_wdata}, 64'd0);
            end
            if (if_rvalid || ls_rvalid) begin
                if (!in_flight) begin
                    chk("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    chk("rvalid_owner", {63'd0, ls_rvalid}, {63'd0, cur.ls});
                    chk("rdata", {32'd0, rdata}, {32'd0, cur.rdata});
                    chk("latency", 64'(cyc - gnt_cyc), 64'(LAT + 1));
                    in_flight = 0;
                end
            end
        end
    end

    task automatic req(input bit ls, input logic [31:0] a, input bit we, input logic [31:0] wd);
        int n = 0;
        @(posedge clk); #1;
        if (ls) begin ls_req = 1; ls_addr = a; ls_we = we; ls_wdata = wd; end
        else    begin if_req = 1; if_addr = a; end
        do begin
            @(negedge clk);
            n++;
        end while (!(ls ? ls_gnt : if_gnt) && n < 20);
        if (!(ls ? ls_gnt : if_gnt)) chk("gnt_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        // Scribble the inputs after grant: the latched copy must be used.
        if (ls) begin ls_req = 0; ls_addr = 32'hFFFF_FFFF; ls_we = 0; ls_wdata = 32'h1234_5678; end
        else    begin if_req = 0; if_addr = 32'hFFFF_FFFF; end
    endtask

    initial begin
        int gc[4];
        int ng;
        int n;
        int last_g;
        int brun;
        int bcnt;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gc[4];
        int ng;
        int n;
        int last_g;
        int brun;
        int bcnt;

        reset = 1; if_req = 0; ls_req = 0; ls_we = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0;
        b_reset = 1; b_if_req = 0; b_if_addr = 0;

        // Reset held two cycles
        @(posedge clk);
        @(negedge clk);
        chk("rst_out", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we, mem_sel, 57'd0}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_bus", {mem_addr, mem_wdata}, 64'd0);
        chk("rst_state", {62'd0, dut.state}, 64'd0);
        @(posedge clk); #1 reset = 0;

        // IF alone
        exp_q.push_back('{ls:1'b0, addr:32'h10, we:1'b0, wdata:32'h0, rdata:32'h0050_0093});
        req(0, 32'h10, 0, 0);
        repeat (4) @(posedge clk);

        // LS store
        exp_q.push_back('{ls:1'b1, addr:32'h100, we:1'b1, wdata:32'hDEAD_BEEF, rdata:32'h0});
        req(1, 32'h100, 1, 32'hDEAD_BEEF);
        repeat (4) @(posedge clk);

        // Both held: IF, LS, IF, LS spaced MEM_LAT+2 apart
        exp_q.push_back('{ls:1'b0, addr:32'h20,  we:1'b0, wdata:32'h0, rdata:32'h0050_00A3});
        exp_q.push_back('{ls:1'b1, addr:32'h200, we:1'b0, wdata:32'h0, rdata:32'h0050_0283});
        exp_q.push_back('{ls:1'b0, addr:32'h20,  we:1'b0, wdata:32'h0, rdata:32'h0050_00A3});
        exp_q.push_back('{ls:1'b1, addr:32'h200, we:1'b0, wdata:32'h0, rdata:32'h0050_0283});
        @(posedge clk); #1;
        if_req = 1; if_addr = 32'h20; ls_req = 1; ls_addr = 32'h200; ls_we = 0; ls_wdata = 0;
        ng = 0; n = 0;
        while (ng < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (if_gnt || ls_gnt) begin gc[ng] = cyc; ng++; end
        end
        chk("tie_gnt_count", 64'(ng), 64'd4);
        @(posedge clk); #1 if_req = 0; ls_req = 0;
        for (int i = 1; i < 4; i++)
            if (i < ng) chk("tie_gnt_spacing", 64'(gc[i] - gc[i-1]), 64'(LAT + 2));
        repeat (6) @(posedge clk);

        // Reset on first ACCESS cycle abandons the transaction
        exp_q.push_back('{ls:1'b0, addr:32'h30, we:1'b0, wdata:32'h0, rdata:32'h0050_00B3});
        req(0, 32'h30, 0, 0);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("abort_out", {mem_req, if_rvalid, ls_rvalid, mem_sel, 60'd0}, 64'd0);
        chk("abort_rdata", {32'd0, rdata}, 64'd0);
        repeat (5) @(posedge clk);
        exp_q.push_back('{ls:1'b0, addr:32'h40, we:1'b0, wdata:32'h0, rdata:32'h0050_00C3});
        req(0, 32'h40, 0, 0);
        repeat (5) @(posedge clk);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("none_in_flight", {63'd0, in_flight}, 64'd0);

        // MEM_LAT=1 instance, IF held high
        @(posedge clk); #1 b_reset = 0; b_if_req = 1; b_if_addr = 32'h50;
        last_g = -1; brun = 0; bcnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (b_if_gnt) begin
                if (last_g >= 0) chk("l1_gnt_spacing", 64'(cyc - last_g), 64'd3);
                last_g = cyc;
                bcnt++;
            end
            if (b_mem_req) brun++;
            else begin
                if (brun != 0) chk("l1_mem_req_width", 64'(brun), 64'd1);
                brun = 0;
            end
            if (b_if_rvalid) begin
                chk("l1_latency", 64'(cyc - last_g), 64'd2);
                chk("l1_rdata", {32'd0, b_rdata}, {32'd0, 32'h0050_00D3});
            end
        end
        chk("l1_gnt_count_ge4", {63'd0, bcnt >= 4}, 64'd1);
        b_if_req = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
